fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline, sitting directly upstream of the decode-stage controller. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered with their PCs, and the instruction/PC pair is registered into the IF/ID boundary that the decoder consumes. It honours decode stalls, decode flushes and execute-stage redirects (taken branch, jal, jalr).

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage with request/grant imem port and IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pcf;
  logic [31:0]   pend_q [DEPTH];
  logic [AW-1:0] pend_wr, pend_rd;
  logic [31:0]   buf_pc [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic [AW-1:0] buf_wr, buf_rd;
  logic [CW-1:0] count, outstanding, drop;
  logic [CW:0]   inflight;
  logic          issue, accept, pop;

  // Buffered plus in-flight words never exceed DEPTH, so a response always finds room.
  assign inflight  = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = !PCSrcE && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = pcf;
  assign issue     = imem_req && imem_gnt;
  assign accept    = imem_rvalid && !PCSrcE && (drop == '0);
  assign pop       = !FlushD && !StallD && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf         <= RESET_PC;
      pend_wr     <= '0;
      pend_rd     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (PCSrcE) begin
      // Every request still in flight belongs to the old path and must be discarded.
      pcf         <= PCTargetE;
      pend_wr     <= '0;
      pend_rd     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(imem_rvalid);
      drop        <= outstanding - CW'(imem_rvalid);
    end else begin
      if (issue) begin
        pcf     <= pcf + 32'd4;
        pend_wr <= pend_wr + 1'b1;
      end
      if (accept) begin
        pend_rd <= pend_rd + 1'b1;
        buf_wr  <= buf_wr + 1'b1;
      end
      if (pop) buf_rd <= buf_rd + 1'b1;
      count       <= count + CW'(accept) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pend_q[pend_wr] <= pcf;
    if (accept) begin
      buf_pc[buf_wr]    <= pend_q[pend_rd];
      buf_instr[buf_wr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
    end else if (count != '0) begin
      InstrD   <= buf_instr[buf_rd];
      PCD      <= buf_pc[buf_rd];
      PCPlus4D <= buf_pc[buf_rd] + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a fixed-latency imem model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = '0;
  int          lat = 1;
  logic        gnt_en = 1'b1;

  logic        p_v [4];
  logic [31:0] p_d [4];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Memory returns the word address as data, exactly lat cycles after the grant.
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = p_v[0];
  assign imem_rdata  = p_d[0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        p_v[i] <= 1'b0;
        p_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        p_v[i] <= p_v[i+1];
        p_d[i] <= p_d[i+1];
      end
      p_v[3] <= 1'b0;
      if (imem_req && imem_gnt) begin
        p_v[lat-1] <= 1'b1;
        p_d[lat-1] <= imem_addr;
      end
    end
  end

  task automatic do_reset(input int l);
    rst_n = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0; PCTargetE = '0; gnt_en = 1'b1;
    @(negedge clk);
    lat = l;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0; gnt_en = 1'b1; lat = 1;
    @(negedge clk);
    checks += 5;
    if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ValidD); end
    if (InstrD !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", InstrD); end
    if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h expected 0", PCD); end
    if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4: got %h expected 0", PCPlus4D); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks += 2;
      if (imem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_addr: got %h expected %h", imem_addr, 32'(4*k)); end
      if (ValidD !== (k >= 3)) begin errors++; $display("FAIL stream_valid cycle %0d: got %b expected %b", k, ValidD, (k >= 3)); end
      if (k >= 3) begin
        checks += 3;
        if (PCD !== exp_pc) begin errors++; $display("FAIL stream_pcd: got %h expected %h", PCD, exp_pc); end
        if (InstrD !== exp_pc) begin errors++; $display("FAIL stream_instr: got %h expected %h", InstrD, exp_pc); end
        if (PCPlus4D !== exp_pc + 4) begin errors++; $display("FAIL stream_pcplus4: got %h expected %h", PCPlus4D, exp_pc + 4); end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_gnt_stall();
    int h = 0;
    int bubbles = 0;
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks += 2;
        if (PCD !== exp_pc) begin errors++; $display("FAIL gnt_pcd: got %h expected %h", PCD, exp_pc); end
        if (InstrD !== exp_pc) begin errors++; $display("FAIL gnt_instr: got %h expected %h", InstrD, exp_pc); end
        exp_pc += 4;
      end else if (exp_pc != 0) bubbles++;
      if (h == 0 && imem_addr === 32'h10) begin
        gnt_en = 1'b0;
        h = 1;
      end else if (h >= 1 && h <= 3) begin
        checks += 2;
        if (imem_addr !== 32'h10) begin errors++; $display("FAIL gnt_addr_hold: got %h expected 00000010", imem_addr); end
        if (imem_req !== 1'b1) begin errors++; $display("FAIL gnt_req_hold: got %b expected 1", imem_req); end
        if (h == 3) gnt_en = 1'b1;
        h++;
      end
    end
    checks += 3;
    if (h != 4) begin errors++; $display("FAIL gnt_window: got %0d expected 4", h); end
    if (bubbles == 0) begin errors++; $display("FAIL gnt_bubbles: got 0 expected >0"); end
    if (exp_pc < 32'h60) begin errors++; $display("FAIL gnt_progress: got %h expected >=00000060", exp_pc); end
  endtask

  task automatic test_decode_stall();
    int nv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (ValidD !== 1'b1) begin errors++; $display("FAIL pre_stall_valid: got %b expected 1", ValidD); end
      if (PCD !== exp_pc) begin errors++; $display("FAIL pre_stall_pcd: got %h expected %h", PCD, exp_pc); end
      exp_pc += 4;
    end
    StallD = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      checks += 3;
      if (ValidD !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", ValidD); end
      if (PCD !== exp_pc - 4) begin errors++; $display("FAIL stall_pcd: got %h expected %h", PCD, exp_pc - 4); end
      if (InstrD !== exp_pc - 4) begin errors++; $display("FAIL stall_instr: got %h expected %h", InstrD, exp_pc - 4); end
      if (s == 6) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full: got %b expected 0", imem_req); end
      end
    end
    StallD = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks += 2;
        if (PCD !== exp_pc) begin errors++; $display("FAIL post_stall_pcd: got %h expected %h", PCD, exp_pc); end
        if (PCPlus4D !== exp_pc + 4) begin errors++; $display("FAIL post_stall_pcplus4: got %h expected %h", PCPlus4D, exp_pc + 4); end
        exp_pc += 4;
        nv++;
      end
    end
    checks++;
    if (nv != 16) begin errors++; $display("FAIL post_stall_rate: got %0d expected 16", nv); end
  endtask

  task automatic test_redirect();
    int nv = 0;
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h8) begin errors++; $display("FAIL redir_pre_addr: got %h expected 00000008", imem_addr); end
    PCSrcE = 1'b1; PCTargetE = 32'h200; FlushD = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req); end
    @(negedge clk);
    checks += 2;
    if (imem_addr !== 32'h200) begin errors++; $display("FAIL redir_addr: got %h expected 00000200", imem_addr); end
    if (ValidD !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", ValidD); end
    PCSrcE = 1'b0; FlushD = 1'b0;
    exp_pc = 32'h200;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks += 2;
        if (PCD !== exp_pc) begin errors++; $display("FAIL redir_pcd: got %h expected %h", PCD, exp_pc); end
        if (InstrD !== exp_pc) begin errors++; $display("FAIL redir_instr: got %h expected %h", InstrD, exp_pc); end
        exp_pc += 4;
        nv++;
      end
    end
    checks++;
    if (nv < 4) begin errors++; $display("FAIL redir_progress: got %0d expected >=4", nv); end
  endtask

  task automatic test_redirect_rvalid();
    int nv = 0;
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks++;
        if (PCD !== exp_pc) begin errors++; $display("FAIL rv_pre_pcd: got %h expected %h", PCD, exp_pc); end
        exp_pc += 4;
      end
    end
    checks++;
    if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rv_setup: got %b expected 1", imem_rvalid); end
    PCSrcE = 1'b1; PCTargetE = 32'h300; FlushD = 1'b1;
    @(negedge clk);
    checks += 2;
    if (imem_addr !== 32'h300) begin errors++; $display("FAIL rv_addr: got %h expected 00000300", imem_addr); end
    if (ValidD !== 1'b0) begin errors++; $display("FAIL rv_flush: got %b expected 0", ValidD); end
    PCSrcE = 1'b0; FlushD = 1'b0;
    exp_pc = 32'h300;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks += 2;
        if (PCD !== exp_pc) begin errors++; $display("FAIL rv_pcd: got %h expected %h", PCD, exp_pc); end
        if (InstrD !== exp_pc) begin errors++; $display("FAIL rv_instr: got %h expected %h", InstrD, exp_pc); end
        exp_pc += 4;
        nv++;
      end
    end
    checks++;
    if (nv < 4) begin errors++; $display("FAIL rv_progress: got %0d expected >=4", nv); end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    do_reset(3);
    for (int k = 0; k < 10; k++) @(negedge clk);
    PCSrcE = 1'b1; PCTargetE = 32'h400; FlushD = 1'b1;
    @(negedge clk);
    PCTargetE = 32'h500;
    @(negedge clk);
    checks += 2;
    if (imem_addr !== 32'h500) begin errors++; $display("FAIL b2b_addr: got %h expected 00000500", imem_addr); end
    if (ValidD !== 1'b0) begin errors++; $display("FAIL b2b_flush: got %b expected 0", ValidD); end
    PCSrcE = 1'b0; FlushD = 1'b0;
    exp_pc = 32'h500;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks += 2;
        if (PCD !== exp_pc) begin errors++; $display("FAIL b2b_pcd: got %h expected %h", PCD, exp_pc); end
        if (InstrD !== exp_pc) begin errors++; $display("FAIL b2b_instr: got %h expected %h", InstrD, exp_pc); end
        exp_pc += 4;
        nv++;
      end
    end
    checks++;
    if (nv < 4) begin errors++; $display("FAIL b2b_progress: got %0d expected >=4", nv); end
  endtask

  task automatic test_mid_reset();
    int nv = 0;
    do_reset(1);
    for (int k = 0; k < 8; k++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (ValidD !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ValidD); end
    if (InstrD !== 32'h13) begin errors++; $display("FAIL midrst_instr: got %h expected 00000013", InstrD); end
    if (PCD !== 32'h0) begin errors++; $display("FAIL midrst_pcd: got %h expected 0", PCD); end
    if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL midrst_pcplus4: got %h expected 0", PCPlus4D); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ValidD === 1'b1) begin
        checks++;
        if (PCD !== exp_pc) begin errors++; $display("FAIL midrst_pcd_stream: got %h expected %h", PCD, exp_pc); end
        exp_pc += 4;
        nv++;
      end
    end
    checks++;
    if (nv != 8) begin errors++; $display("FAIL midrst_restart: got %0d expected 8", nv); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_stall();
    test_decode_stall();
    test_redirect();
    test_redirect_rvalid();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
